pwm_deadtime: RTL and testbench
===============================

PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the dead-time values and the counter.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  the reset, synchronous and active-high.
REQ-004 SHALL have port pwm_in  input  1  registered PWM from the upstream pwm channel, same clock domain, no synchronizer.
REQ-005 SHALL have port enable  input  1  level; 0 forces both outputs low.
REQ-006 SHALL have port cfg_wen  input  1  one-cycle strobe that loads dead_rise_in and dead_fall_in into the shadow registers.
REQ-007 SHALL have port dead_rise_in  input  CNT_W  number of cycles both outputs are low before pwm_hi asserts.
REQ-008 SHALL have port dead_fall_in  input  CNT_W  number of cycles both outputs are low before pwm_lo asserts.
REQ-009 SHALL have port pwm_hi  output  1  high-side gate drive, active-high, registered.
REQ-010 SHALL have port pwm_lo  output  1  low-side gate drive, active-high, registered.
REQ-011 SHALL have port dt_active  output  1  high while a dead interval is in progress.
REQ-012 SHALL have port pulse_drop  output  1  one-cycle strobe when an input pulse shorter than its dead time is swallowed.

Function
REQ-013 SHALL implement the FSM states OFF, LO_ON, DT_RISE, HI_ON, DT_FALL.
REQ-014 SHALL drive the outputs per state: OFF hi=0 lo=0; LO_ON lo=1; HI_ON hi=1; DT_RISE and DT_FALL hi=0 lo=0 with dt_active=1.
REQ-015 SHALL never assert pwm_hi and pwm_lo together in any cycle, including on enable toggles and configuration changes.
REQ-016 SHALL go to OFF at the next edge whenever enable=0 is sampled, from any state, with the counter cleared.
REQ-017 SHALL leave OFF when enable=1 is sampled: to LO_ON if pwm_in=0; to DT_RISE if pwm_in=1 and the rise shadow is nonzero; to HI_ON if pwm_in=1 and the rise shadow is 0.
REQ-018 SHALL, in LO_ON, on sampling pwm_in=1 at edge E, enter DT_RISE at E, drop lo at E, and load the counter with rise_shadow-1.
REQ-019 SHALL enter HI_ON directly at E when rise_shadow=0, giving lo=0 and hi=1 at the same edge (bypass).
REQ-020 SHALL, in DT_RISE, decrement the counter each cycle and enter HI_ON at the edge after the counter is 0, so hi first asserts at edge E+N, where N=rise_shadow.
REQ-021 SHALL implement DT_FALL as the mirror of REQ-018 to REQ-020, triggered from HI_ON by pwm_in=0 and using fall_shadow, ending in LO_ON.
REQ-022 SHALL, when pwm_in=0 is sampled in DT_RISE, return to LO_ON at that edge and pulse pulse_drop for one cycle.
REQ-023 SHALL, when pwm_in=1 is sampled in DT_FALL, return to HI_ON at that edge and pulse pulse_drop for one cycle.
REQ-024 SHALL give pulse_drop priority below enable=0: a simultaneous disable goes to OFF with no strobe.
REQ-025 SHALL update the shadow registers on cfg_wen at any time.
REQ-026 SHALL sample the shadow registers only at dead-interval entry, so a write during an interval does not alter that interval.
REQ-027 SHALL use the new shadow value for a dead interval entered on the same edge as cfg_wen.
REQ-028 SHALL load a maximum dead value of 2^CNT_W-1 without wrap; the counter never underflows.

Reset
REQ-029 SHALL, with rst=1 at an edge, set state=OFF, counter=0, shadows=0, and pwm_hi=pwm_lo=dt_active=pulse_drop=0.
REQ-030 SHALL give rst priority over enable and cfg_wen.
REQ-031 SHALL, on rst asserted mid-interval or while HI_ON, drop all outputs at that edge.

Structure
REQ-032 SHALL take the FSM state enum (pwm_dt_state_t) and the default CNT_W constant from the shared package pwm_pkg.
REQ-033 SHALL contain no sub-module; the counter is inline, and the existing async-reset flex_counter is not reused because its reset style differs.

Verification
REQ-034 SHALL cover basic dead time: rise=3, fall=2, enable=1, pwm_in low 10 then high 10 -> lo falls at the rise edge E, hi rises at E+3, and on the fall edge F hi falls at F and lo rises at F+2.
REQ-035 SHALL cover zero dead time: rise=fall=0, toggle pwm_in every 4 cycles -> hi/lo swap at the same edge, dt_active never 1.
REQ-036 SHALL cover a short pulse: rise=5, a 2-cycle pwm_in high pulse -> hi never asserts, lo returns after 2 cycles, pulse_drop=1 for exactly one cycle.
REQ-037 SHALL cover disable mid-interval: enable=0 during DT_RISE -> both outputs 0 next edge; re-enable with pwm_in=1 and rise=4 -> hi at +4.
REQ-038 SHALL cover a config write mid-interval: rise=8, cfg_wen with rise=2 at cycle 3 of the interval -> the current interval stays 8 and the next rise uses 2.
REQ-039 SHALL cover reset: rst during HI_ON -> all outputs 0 and shadows 0, so the next rise after enable is a 0-cycle bypass; an assertion checks hi&lo is never 1 across all tests.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stages: dead-time FSM states and the
// default dead-time counter width.
package pwm_pkg;

  localparam int PWM_CNT_W = 16;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    LO_ON   = 3'd1,
    DT_RISE = 3'd2,
    HI_ON   = 3'd3,
    DT_FALL = 3'd4
  } pwm_dt_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with programmable dead time on both edges
// of an incoming PWM, swallowing pulses shorter than their dead interval.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             enable,
  input  logic             cfg_wen,
  input  logic [CNT_W-1:0] dead_rise_in,
  input  logic [CNT_W-1:0] dead_fall_in,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic             dt_active,
  output logic             pulse_drop
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pwm_dt_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rise_sh_q, rise_sh_d;
  logic [CNT_W-1:0] fall_sh_q, fall_sh_d;
  logic             hi_q, hi_d, lo_q, lo_d, dt_q, dt_d, drop_q, drop_d;

  // Shadow registers; the _d value is also what a same-edge interval entry uses
  always_comb begin
    if (cfg_wen) begin
      rise_sh_d = dead_rise_in;
      fall_sh_d = dead_fall_in;
    end else begin
      rise_sh_d = rise_sh_q;
      fall_sh_d = fall_sh_q;
    end
  end

  // Next-state logic; the counter is only loaded on interval entry and only decremented while nonzero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    if (!enable) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF, LO_ON: begin
          if (pwm_in) begin
            if (rise_sh_d != '0) begin
              state_d = DT_RISE;
              cnt_d   = rise_sh_d - CNT_ONE;
            end else begin
              state_d = HI_ON;
              cnt_d   = '0;
            end
          end else begin
            state_d = LO_ON;
            cnt_d   = '0;
          end
        end
        DT_RISE: begin
          if (!pwm_in) begin
            state_d = LO_ON;
            cnt_d   = '0;
            drop_d  = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = HI_ON;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HI_ON: begin
          if (!pwm_in) begin
            if (fall_sh_d != '0) begin
              state_d = DT_FALL;
              cnt_d   = fall_sh_d - CNT_ONE;
            end else begin
              state_d = LO_ON;
              cnt_d   = '0;
            end
          end else begin
            state_d = HI_ON;
          end
        end
        DT_FALL: begin
          if (pwm_in) begin
            state_d = HI_ON;
            cnt_d   = '0;
            drop_d  = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = LO_ON;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode from the next state so they are registered alongside it
  always_comb begin
    hi_d = (state_d == HI_ON);
    lo_d = (state_d == LO_ON);
    dt_d = (state_d == DT_RISE) || (state_d == DT_FALL);
  end

  // State, counter, shadow and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      rise_sh_q <= '0;
      fall_sh_q <= '0;
      hi_q      <= 1'b0;
      lo_q      <= 1'b0;
      dt_q      <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rise_sh_q <= rise_sh_d;
      fall_sh_q <= fall_sh_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dt_q      <= dt_d;
      drop_q    <= drop_d;
    end
  end

  assign pwm_hi     = hi_q;
  assign pwm_lo     = lo_q;
  assign dt_active  = dt_q;
  assign pulse_drop = drop_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime; outputs compared as {hi, lo, dt_active, pulse_drop}.
module tb_pwm_deadtime;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic        enable;
  logic        cfg_wen;
  logic [15:0] dead_rise_in;
  logic [15:0] dead_fall_in;
  logic        pwm_hi, pwm_lo, dt_active, pulse_drop;
  logic [3:0]  obs;
  int          checks   = 0;
  int          failures = 0;

  pwm_deadtime #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .enable       (enable),
    .cfg_wen      (cfg_wen),
    .dead_rise_in (dead_rise_in),
    .dead_fall_in (dead_fall_in),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .dt_active    (dt_active),
    .pulse_drop   (pulse_drop)
  );

  always #5 clk = ~clk;

  assign obs = {pwm_hi, pwm_lo, dt_active, pulse_drop};

  assert property (@(negedge clk) !(pwm_hi && pwm_lo));

  // advance n edges; sample 1 time unit after each edge and check no overlap
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ((pwm_hi & pwm_lo) !== 1'b0) begin
        failures++;
        $display("FAIL overlap t=%0t hi=%b lo=%b required not both 1", $time, pwm_hi, pwm_lo);
      end
    end
  endtask

  task automatic cfg(input logic [15:0] r, input logic [15:0] f);
    cfg_wen = 1'b1; dead_rise_in = r; dead_fall_in = f;
    tick(1);
    cfg_wen = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; pwm_in = 1'b1; cfg_wen = 1'b1;
    dead_rise_in = 16'd7; dead_fall_in = 16'd7;
    tick(2);
    checks++;
    if (obs !== 4'b0000) begin
      failures++; $display("FAIL reset got=%b required=0000", obs);
    end
    rst = 1'b0; cfg_wen = 1'b0; enable = 1'b0; pwm_in = 1'b0;
    tick(1);
  endtask

  task automatic test_basic;
    logic [3:0] exp_v [0:2];
    cfg(16'd3, 16'd2);
    enable = 1'b1; pwm_in = 1'b0;
    tick(1);
    checks++;
    if (obs !== 4'b0100) begin failures++; $display("FAIL basic_lo_on got=%b required=0100", obs); end
    tick(9);
    pwm_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      checks++;
      if (obs !== ((k == 3) ? 4'b1000 : 4'b0010)) begin
        failures++; $display("FAIL basic_rise E+%0d got=%b", k, obs);
      end
    end
    tick(6);
    pwm_in = 1'b0;
    exp_v[0] = 4'b0010; exp_v[1] = 4'b0010; exp_v[2] = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++;
      if (obs !== exp_v[k]) begin
        failures++; $display("FAIL basic_fall F+%0d got=%b required=%b", k, obs, exp_v[k]);
      end
    end
  endtask

  task automatic test_zero;
    cfg(16'd0, 16'd0);
    for (int t = 0; t < 6; t++) begin
      pwm_in = ~pwm_in;
      for (int c = 0; c < 4; c++) begin
        tick(1);
        checks++;
        if (obs !== {pwm_in, ~pwm_in, 2'b00}) begin
          failures++; $display("FAIL zero_dt t=%0d c=%0d got=%b required=%b", t, c, obs, {pwm_in, ~pwm_in, 2'b00});
        end
      end
    end
  endtask

  task automatic test_short;
    logic [3:0] exp_v [0:3];
    cfg(16'd5, 16'd0);
    exp_v[0] = 4'b0010; exp_v[1] = 4'b0010; exp_v[2] = 4'b0101; exp_v[3] = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      pwm_in = (k < 2);
      tick(1);
      checks++;
      if (obs !== exp_v[k]) begin
        failures++; $display("FAIL short_pulse E+%0d got=%b required=%b", k, obs, exp_v[k]);
      end
    end
  endtask

  task automatic test_disable;
    cfg(16'd4, 16'd0);
    pwm_in = 1'b1;
    tick(2);
    checks++;
    if (obs !== 4'b0010) begin failures++; $display("FAIL dis_in_dt got=%b required=0010", obs); end
    enable = 1'b0;
    tick(1);
    checks++;
    if (obs !== 4'b0000) begin failures++; $display("FAIL dis_off got=%b required=0000", obs); end
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      checks++;
      if (obs !== ((k == 4) ? 4'b1000 : 4'b0010)) begin
        failures++; $display("FAIL dis_reenable R+%0d got=%b", k, obs);
      end
    end
    cfg(16'd4, 16'd3);
    pwm_in = 1'b0;
    tick(1);
    checks++;
    if (obs !== 4'b0010) begin failures++; $display("FAIL dis_dt_fall got=%b required=0010", obs); end
    pwm_in = 1'b1; enable = 1'b0;
    tick(1);
    checks++;
    if (obs !== 4'b0000) begin failures++; $display("FAIL dis_drop_prio got=%b required=0000", obs); end
    enable = 1'b1; pwm_in = 1'b0;
    tick(1);
    checks++;
    if (obs !== 4'b0100) begin failures++; $display("FAIL dis_back_lo got=%b required=0100", obs); end
  endtask

  task automatic test_cfg_mid;
    cfg(16'd8, 16'd0);
    pwm_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cfg_wen = (k == 3); dead_rise_in = 16'd2;
      tick(1);
      checks++;
      if (obs !== ((k == 8) ? 4'b1000 : 4'b0010)) begin
        failures++; $display("FAIL cfg_mid_old E+%0d got=%b", k, obs);
      end
    end
    cfg_wen = 1'b0;
    pwm_in = 1'b0;
    tick(1);
    pwm_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++;
      if (obs !== ((k == 2) ? 4'b1000 : 4'b0010)) begin
        failures++; $display("FAIL cfg_mid_new G+%0d got=%b", k, obs);
      end
    end
    pwm_in = 1'b0;
    tick(1);
    cfg_wen = 1'b1; dead_rise_in = 16'd1; pwm_in = 1'b1;
    tick(1);
    cfg_wen = 1'b0;
    checks++;
    if (obs !== 4'b0010) begin failures++; $display("FAIL cfg_same_edge_dt got=%b required=0010", obs); end
    tick(1);
    checks++;
    if (obs !== 4'b1000) begin failures++; $display("FAIL cfg_same_edge_hi got=%b required=1000", obs); end
  endtask

  task automatic test_max;
    pwm_in = 1'b0;
    tick(1);
    cfg(16'hFFFF, 16'd0);
    pwm_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      checks++;
      if (obs !== 4'b0010) begin failures++; $display("FAIL max_dead k=%0d got=%b required=0010", k, obs); end
    end
    enable = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_hion;
    cfg(16'd3, 16'd3);
    enable = 1'b1; pwm_in = 1'b1;
    tick(4);
    checks++;
    if (obs !== 4'b1000) begin failures++; $display("FAIL rst_pre_hi got=%b required=1000", obs); end
    rst = 1'b1;
    tick(1);
    checks++;
    if (obs !== 4'b0000) begin failures++; $display("FAIL rst_hion got=%b required=0000", obs); end
    rst = 1'b0;
    tick(1);
    checks++;
    if (obs !== 4'b1000) begin failures++; $display("FAIL rst_bypass_rise got=%b required=1000", obs); end
    pwm_in = 1'b0;
    tick(1);
    checks++;
    if (obs !== 4'b0100) begin failures++; $display("FAIL rst_bypass_fall got=%b required=0100", obs); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_short;
    test_disable;
    test_cfg_mid;
    test_max;
    test_reset_hion;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
